axi_lite_spi_regs: RTL and testbench
====================================

Name: axi_lite_spi_regs

Overview:
- AXI4-Lite slave register bank. It terminates the AXI-Lite master's AR/R and AW/W/B channels and presents a control/data interface to the downstream SPI engine.
- Four 32-bit word registers: CTRL, TXDATA, RXDATA, STATUS. SPI transfers are started by software writes. Results are captured for later AXI reads.

Parameters:
- CTRL_RST, 32'h0000_0000, reset value of CTRL[31:1] (bit0 always resets to 0)
- TX_RST, 32'h0000_0000, reset value of TXDATA

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  32  write address; only bits [3:2] decoded
- AWPROT  in  3  ignored
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  32  write data
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  write response
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARADDR  in  32  read address; only bits [3:2] decoded
- ARPROT  in  3  ignored
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  32  read data
- RRESP  out  2  read response, always 2'b00
- spi_start  out  1  one-cycle start pulse to SPI engine
- spi_tx_data  out  32  equals TXDATA register
- spi_busy  in  1  SPI engine transfer in progress
- spi_done  in  1  one-cycle pulse, spi_rx_data valid
- spi_rx_data  in  32  received word

Behaviour:
- Register map (ADDR[3:2]); upper address bits ignored, so the map aliases:
  - 0 CTRL, RW: bit0 START is write-1 and reads 0; bit1 ERR_CLR is write-1 and clears STATUS.err; other bits plain RW.
  - 1 TXDATA, RW.
  - 2 RXDATA, RO.
  - 3 STATUS, RO: bit0 = spi_busy (live), bit1 = rx_valid, bit2 = err, rest 0.
- Reset values: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, spi_start=0, RXDATA=0, rx_valid=0, err=0, CTRL=CTRL_RST with bit0=0, TXDATA=TX_RST.
- Write path, independent AW and W capture:
  - AWREADY=1 while no address is held and BVALID=0. WREADY=1 while no data is held and BVALID=0.
  - Ready signals drop the cycle after their handshake.
  - AW and W may arrive in either order or in the same cycle.
- Write commit: when address and data are both held (cycle N edge):
  - The register updates and BVALID=1 from N+1. BVALID holds until BREADY; the held flags clear on the B handshake.
  - BRESP=2'b00 for offsets 0/1. For offsets 2/3, BRESP=2'b10 (SLVERR) and the write is ignored.
- START handling:
  - Write to CTRL with WDATA[0]=1 and spi_busy=0 gives spi_start=1 for exactly cycle N+1.
  - If spi_busy=1, no pulse is issued, err is set sticky, and BRESP remains 2'b00.
  - spi_start is never asserted for two consecutive cycles.
- Read path:
  - ARREADY=1 while RVALID=0.
  - Handshake at cycle N: RDATA is loaded from the register state as it was before edge N, and RVALID=1 from N+1.
  - RDATA is held stable until RREADY. ARREADY=0 while RVALID=1.
- RXDATA capture: spi_done=1 loads spi_rx_data and sets rx_valid.
- rx_valid clears on the R handshake of an RXDATA read. Set wins if spi_done coincides with that clearing handshake.
- Simultaneous read and write to the same register: the read returns the old value.
- ERR_CLR with a busy-START in the same write: err ends set (set wins).
- ARESET mid-transaction:
  - All outstanding AW/W/AR state is dropped and all outputs return to reset values the next cycle.
  - No B or R response is issued for aborted transactions.

Test Plan:
- Write 0xA5A5_0001 to 0x4, then read 0x4 -> BRESP=00, RDATA=0xA5A5_0001, spi_tx_data=0xA5A5_0001; RVALID one cycle after AR handshake.
- W presented 3 cycles before AW (addr 0x0, data 0x1), spi_busy=0 -> single spi_start pulse the cycle after AW handshake; BVALID held while BREADY is held low 4 cycles; subsequent CTRL read bit0=0.
- spi_done with spi_rx_data=0x1234_5678 -> STATUS read=0x2 (busy=0); RXDATA read=0x1234_5678; STATUS read afterwards=0x0.
- START write while spi_busy=1 -> no spi_start, BRESP=00, STATUS=0x5; CTRL write 0x2 -> STATUS=0x1.
- Write to 0x8 -> BRESP=10, RXDATA unchanged; read 0x1C (aliases 0xC) returns STATUS.
- Assert ARESET while RVALID=1 and RREADY=0 -> RVALID=0 next cycle, TXDATA=TX_RST; no spurious spi_start.

Source files
------------

// File: rtl/axi_lite_spi_regs.sv
// -----------------------------------------------------------------------------
// axi_lite_spi_regs
//
// AXI4-Lite slave register bank that fronts a simple SPI engine. Software
// starts transfers by writing CTRL.START. Received words are captured into
// RXDATA for later reads.
//
// Register map (ADDR[3:2], upper address bits ignored, so the map aliases):
//   0 CTRL    RW  bit0 START (write-1 pulse, reads 0), bit1 ERR_CLR (write-1
//                 clears STATUS.err, stored like the other bits)
//   1 TXDATA  RW  drives spi_tx_data
//   2 RXDATA  RO  last spi_rx_data captured on spi_done
//   3 STATUS  RO  {29'b0, err, rx_valid, spi_busy(live)}
// Writes to offsets 2/3 are ignored and answered with SLVERR.
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   AW*/W*/B*           AXI4-Lite write channels (AWPROT ignored)
//   AR*/R*              AXI4-Lite read channels (ARPROT ignored)
//   spi_start           one-cycle start pulse to the SPI engine
//   spi_tx_data         current TXDATA value
//   spi_busy            SPI engine transfer in progress
//   spi_done            one-cycle pulse, spi_rx_data valid
//   spi_rx_data         received word
// -----------------------------------------------------------------------------
module axi_lite_spi_regs #(
  parameter logic [31:0] CTRL_RST = 32'h0000_0000,
  parameter logic [31:0] TX_RST   = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // Write address channel
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  // Write data channel
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  // Write response channel
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  // Read address channel
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  // Read data channel
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  // SPI engine side
  output logic        spi_start,
  output logic [31:0] spi_tx_data,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [31:0] spi_rx_data
);

  localparam logic [1:0] OffCtrl = 2'd0;
  localparam logic [1:0] OffTx   = 2'd1;
  localparam logic [1:0] OffRx   = 2'd2;
  localparam logic [1:0] OffStat = 2'd3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Write path
  logic        awready_q, awready_d;
  logic        wready_q,  wready_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q,  w_held_d;
  logic [1:0]  awoff_q,   awoff_d;
  logic [31:0] wdata_q,   wdata_d;
  logic        bvalid_q,  bvalid_d;
  logic [1:0]  bresp_q,   bresp_d;
  // Read path
  logic        arready_q, arready_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  roff_q,    roff_d;
  // Register file
  logic [31:1] ctrl_q,    ctrl_d;
  logic [31:0] tx_q,      tx_d;
  logic [31:0] rx_q,      rx_d;
  logic        rx_valid_q, rx_valid_d;
  logic        err_q,     err_d;
  logic        start_q,   start_d;

  // ---------------------------------------------------------------------------
  // Handshakes and decoded write
  // ---------------------------------------------------------------------------
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        commit;
  logic [1:0]  wr_off;
  logic [31:0] wr_data;
  logic        wr_ctrl;
  logic [31:0] status_word;
  logic [31:0] rd_word;

  always_comb begin
    aw_hs   = AWVALID & awready_q;
    w_hs    = WVALID & wready_q;
    b_hs    = bvalid_q & BREADY;
    ar_hs   = ARVALID & arready_q;
    r_hs    = rvalid_q & RREADY;
    // Use the channel payload directly on its handshake cycle so the write
    // commits on the same edge the second half of the pair arrives.
    wr_off  = aw_hs ? AWADDR[3:2] : awoff_q;
    wr_data = w_hs ? WDATA : wdata_q;
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    wr_ctrl = commit & (wr_off == OffCtrl);
  end

  assign status_word = {29'b0, err_q, rx_valid_q, spi_busy};

  // Read mux sees pre-edge register state, so a same-cycle write is not visible.
  always_comb begin
    rd_word = 32'h0;
    unique case (ARADDR[3:2])
      OffCtrl: rd_word = {ctrl_q, 1'b0};
      OffTx:   rd_word = tx_q;
      OffRx:   rd_word = rx_q;
      OffStat: rd_word = status_word;
      default: rd_word = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write channel next state
  // ---------------------------------------------------------------------------
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awoff_d   = awoff_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awoff_d   = AWADDR[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = WDATA;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_off == OffRx || wr_off == OffStat) ? RespSlvErr : RespOkay;
    end else if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    // Registered readies: they drop the cycle after their handshake and stay
    // low until the response has been accepted.
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // ---------------------------------------------------------------------------
  // Register file next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d     = ctrl_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_valid_d = rx_valid_q;
    err_d      = err_q;
    start_d    = 1'b0;

    if (wr_ctrl) begin
      ctrl_d = wr_data[31:1];
    end
    if (commit && wr_off == OffTx) begin
      tx_d = wr_data;
    end

    // START: pulse only when idle; a START against a busy engine is an error.
    // The !start_q term keeps the pulse from ever stretching to two cycles.
    if (wr_ctrl && wr_data[0] && !spi_busy && !start_q) begin
      start_d = 1'b1;
    end

    // ERR_CLR first so a simultaneous busy-START leaves err set.
    if (wr_ctrl && wr_data[1]) begin
      err_d = 1'b0;
    end
    if (wr_ctrl && wr_data[0] && spi_busy) begin
      err_d = 1'b1;
    end

    // rx_valid clears when an RXDATA read completes; a coincident capture wins.
    if (r_hs && roff_q == OffRx) begin
      rx_valid_d = 1'b0;
    end
    if (spi_done) begin
      rx_d       = spi_rx_data;
      rx_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    roff_d   = roff_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      roff_d   = ARADDR[3:2];
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end

    arready_d = ~rvalid_d;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awoff_q    <= 2'b00;
      wdata_q    <= 32'h0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      roff_q     <= 2'b00;
      ctrl_q     <= CTRL_RST[31:1];
      tx_q       <= TX_RST;
      rx_q       <= 32'h0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awoff_q    <= awoff_d;
      wdata_q    <= wdata_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      roff_q     <= roff_d;
      ctrl_q     <= ctrl_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      start_q    <= start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign AWREADY     = awready_q;
  assign WREADY      = wready_q;
  assign BVALID      = bvalid_q;
  assign BRESP       = bresp_q;
  assign ARREADY     = arready_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign RRESP       = RespOkay;
  assign spi_start   = start_q;
  assign spi_tx_data = tx_q;

  // Address bits outside [3:2] and the protection fields carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR[31:4], AWADDR[1:0], ARADDR[31:4], ARADDR[1:0],
                           AWPROT, ARPROT, CTRL_RST[0]};

endmodule

// File: tb/tb_axi_lite_spi_regs.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_spi_regs
//
// Self-checking bench for axi_lite_spi_regs: a table of single AXI-Lite
// transactions with hand-computed results, followed by directed sequences for
// the multi-cycle corners (W before AW, START pulse timing, B backpressure,
// RX capture, busy-START error, rx_valid set/clear collision, mid-read reset).
// -----------------------------------------------------------------------------
module tb_axi_lite_spi_regs;

  localparam logic [31:0] CtrlRst = 32'h0000_0F01;
  localparam logic [31:0] TxRst   = 32'hDEAD_BEEF;
  localparam int unsigned Budget  = 20;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        spi_start;
  logic [31:0] spi_tx_data;
  logic        spi_busy, spi_done;
  logic [31:0] spi_rx_data;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int double_cnt = 0;
  logic start_prev = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_lite_spi_regs #(
    .CTRL_RST(CtrlRst),
    .TX_RST  (TxRst)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .AWADDR     (AWADDR),
    .AWPROT     (AWPROT),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .WDATA      (WDATA),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .BRESP      (BRESP),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .ARADDR     (ARADDR),
    .ARPROT     (ARPROT),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .RDATA      (RDATA),
    .RRESP      (RRESP),
    .spi_start  (spi_start),
    .spi_tx_data(spi_tx_data),
    .spi_busy   (spi_busy),
    .spi_done   (spi_done),
    .spi_rx_data(spi_rx_data)
  );

  // Pulse monitor, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (spi_start) start_cnt++;
    if (spi_start && start_prev) double_cnt++;
    start_prev = spi_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Write with AW and W offered together; returns BRESP.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < Budget) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs)  WVALID = 1'b0;
      n++;
    end
    while (!BVALID && n < Budget) begin
      tick();
      n++;
    end
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr 0x%08h got no BVALID, expected BVALID within %0d cycles",
               a, Budget);
      AWVALID = 1'b0; WVALID = 1'b0;
      resp = 2'bxx;
    end else begin
      resp = BRESP;
      tick();
    end
    BREADY = 1'b0;
  endtask

  // Read; also checks RVALID appears exactly one cycle after the AR handshake.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] data);
    int n;
    logic hs;
    ARADDR = a; ARVALID = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < Budget) begin
      hs = ARREADY;
      tick();
      n++;
    end
    ARVALID = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr 0x%08h got no ARREADY, expected within %0d cycles",
               a, Budget);
      data = 32'hxxxx_xxxx;
    end else begin
      check("rvalid_latency", {31'b0, RVALID}, 32'h1);
      check("rresp", {30'b0, RRESP}, 32'h0);
      data = RDATA;
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;   // BRESP for writes, RDATA for reads
    string       name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic        hs;
    int          n;
    int          starts_before;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,           32'h0000_0F00, "rst_ctrl"};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,           32'hDEAD_BEEF, "rst_tx"};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,           32'h0000_0000, "rst_rx"};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,           32'h0000_0000, "rst_status"};
    vecs[4]  = '{1'b1, 32'h0000_0004, 32'hA5A5_0001,   32'h0,         "wr_tx_bresp"};
    vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,           32'hA5A5_0001, "rd_tx"};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_00F0,   32'h0,         "wr_ctrl_bresp"};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,           32'h0000_00F0, "rd_ctrl"};
    vecs[8]  = '{1'b1, 32'h0000_0008, 32'h1234_5678,   32'h2,         "wr_rx_slverr"};
    vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0,           32'h0000_0000, "rx_unchanged"};
    vecs[10] = '{1'b1, 32'h0000_000C, 32'h0000_0001,   32'h2,         "wr_status_slverr"};
    vecs[11] = '{1'b0, 32'h0000_001C, 32'h0,           32'h0000_0000, "rd_status_alias"};
    vecs[12] = '{1'b1, 32'h0000_0014, 32'h0000_0055,   32'h0,         "wr_tx_alias"};
    vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,           32'h0000_0055, "rd_tx_alias"};

    ARESET = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
    WVALID = 1'b0; WDATA = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; ARPROT = '0; RREADY = 1'b0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = '0;
    repeat (3) tick();

    // Outputs while reset is held
    check("rst_awready", {31'b0, AWREADY}, 32'h0);
    check("rst_wready", {31'b0, WREADY}, 32'h0);
    check("rst_arready", {31'b0, ARREADY}, 32'h0);
    check("rst_bvalid_rvalid", {30'b0, BVALID, RVALID}, 32'h0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_tx_data", spi_tx_data, TxRst);
    ARESET = 1'b0;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, resp);
        check(vecs[i].name, {30'b0, resp}, vecs[i].exp);
      end else begin
        axi_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp);
      end
    end
    check("tx_data_port", spi_tx_data, 32'h0000_0055);
    check("no_start_yet", start_cnt, 0);

    // W three cycles ahead of AW, START with engine idle, B held off 4 cycles
    WDATA = 32'h1; WVALID = 1'b1;
    n = 0;
    while (WVALID && n < Budget) begin
      hs = WREADY;
      tick();
      if (hs) WVALID = 1'b0;
      n++;
    end
    check("w_first_accepted", {31'b0, WVALID}, 32'h0);
    tick(); tick();
    check("no_commit_without_aw", {30'b0, BVALID, spi_start}, 32'h0);
    AWADDR = 32'h0; AWVALID = 1'b1; BREADY = 1'b0;
    n = 0;
    while (AWVALID && n < Budget) begin
      hs = AWREADY;
      tick();
      if (hs) AWVALID = 1'b0;
      n++;
    end
    check("start_after_aw", {31'b0, spi_start}, 32'h1);
    check("bvalid_after_aw", {31'b0, BVALID}, 32'h1);
    tick();
    check("start_one_cycle", {31'b0, spi_start}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("bvalid_held", {31'b0, BVALID}, 32'h1);
      tick();
    end
    check("bresp_start", {30'b0, BRESP}, 32'h0);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_cleared", {31'b0, BVALID}, 32'h0);
    axi_read(32'h0, rd);
    check("ctrl_start_reads0", rd, 32'h0);
    check("one_start_pulse", start_cnt, 1);

    // RX capture and rx_valid clear on RXDATA read
    spi_rx_data = 32'h1234_5678; spi_done = 1'b1;
    tick();
    spi_done = 1'b0; spi_rx_data = 32'h0;
    axi_read(32'hC, rd);
    check("status_rx_valid", rd, 32'h2);
    axi_read(32'h8, rd);
    check("rxdata", rd, 32'h1234_5678);
    axi_read(32'hC, rd);
    check("status_rx_cleared", rd, 32'h0);

    // START while busy: no pulse, err set, OKAY response; ERR_CLR clears
    starts_before = start_cnt;
    spi_busy = 1'b1;
    axi_write(32'h0, 32'h1, resp);
    check("busy_start_bresp", {30'b0, resp}, 32'h0);
    axi_read(32'hC, rd);
    check("status_err_busy", rd, 32'h5);
    axi_write(32'h0, 32'h2, resp);
    axi_read(32'hC, rd);
    check("status_err_cleared", rd, 32'h1);
    // ERR_CLR together with a busy START: set wins
    axi_write(32'h0, 32'h3, resp);
    axi_read(32'hC, rd);
    check("status_set_wins", rd, 32'h5);
    spi_busy = 1'b0;
    axi_write(32'h0, 32'h2, resp);
    axi_read(32'hC, rd);
    check("status_clear_idle", rd, 32'h0);
    check("no_start_when_busy", start_cnt, starts_before);

    // New capture coinciding with the RXDATA read handshake keeps rx_valid
    spi_rx_data = 32'hCAFE_0001; spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    ARADDR = 32'h8; ARVALID = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < Budget) begin
      hs = ARREADY;
      tick();
      n++;
    end
    ARVALID = 1'b0;
    check("collide_rvalid", {31'b0, RVALID}, 32'h1);
    check("collide_rdata", RDATA, 32'hCAFE_0001);
    spi_rx_data = 32'hCAFE_0002; spi_done = 1'b1; RREADY = 1'b1;
    tick();
    spi_done = 1'b0; RREADY = 1'b0;
    axi_read(32'hC, rd);
    check("collide_rx_valid_kept", rd, 32'h2);
    axi_read(32'h8, rd);
    check("collide_rxdata_new", rd, 32'hCAFE_0002);

    // Reset during a held read response
    starts_before = start_cnt;
    ARADDR = 32'h4; ARVALID = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < Budget) begin
      hs = ARREADY;
      tick();
      n++;
    end
    ARVALID = 1'b0;
    tick();
    check("pre_reset_rvalid", {31'b0, RVALID}, 32'h1);
    check("pre_reset_tx", spi_tx_data, 32'h0000_0055);
    ARESET = 1'b1;
    tick();
    check("reset_rvalid", {31'b0, RVALID}, 32'h0);
    check("reset_rdata", RDATA, 32'h0);
    check("reset_tx", spi_tx_data, TxRst);
    check("reset_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h0);
    ARESET = 1'b0;
    tick();
    axi_read(32'h0, rd);
    check("reset_ctrl", rd, 32'h0000_0F00);
    axi_read(32'hC, rd);
    check("reset_status", rd, 32'h0);
    check("no_spurious_start", start_cnt, starts_before);
    check("never_double_pulse", double_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
